// File: rtl/keypad_entry.sv
// 4x4 keypad scanner with per-frame debounce plus enter/clear buttons, feeding a
// hex entry register that is handed to a consumer through a valid/ready handshake.

module keypad_debounce #(
    parameter int DEBOUNCE = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_end,
    input  logic       hit,
    input  logic [3:0] code,
    output logic       accept
);
    localparam logic [3:0] DB = 4'(DEBOUNCE);

    typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, REL_CHK} state_t;

    state_t     state, state_nxt;
    logic [3:0] count, count_nxt;
    logic [3:0] cand, cand_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            count <= '0;
            cand  <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            cand  <= cand_nxt;
        end
    end

    // Only frame ends advance the machine; with DEBOUNCE=1 the check states are skipped.
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        cand_nxt  = cand;
        accept    = 1'b0;
        if (frame_end) begin
            case (state)
                IDLE: begin
                    if (hit) begin
                        cand_nxt = code;
                        if (DB == 4'd1) begin
                            state_nxt = HELD;
                            count_nxt = '0;
                            accept    = 1'b1;
                        end else begin
                            state_nxt = PRESS_CHK;
                            count_nxt = 4'd1;
                        end
                    end
                end
                PRESS_CHK: begin
                    if (hit && code == cand) begin
                        if (count + 4'd1 == DB) begin
                            state_nxt = HELD;
                            count_nxt = '0;
                            accept    = 1'b1;
                        end else begin
                            count_nxt = count + 4'd1;
                        end
                    end else begin
                        state_nxt = IDLE;
                        count_nxt = '0;
                    end
                end
                HELD: begin
                    if (!hit) begin
                        if (DB == 4'd1) begin
                            state_nxt = IDLE;
                            count_nxt = '0;
                        end else begin
                            state_nxt = REL_CHK;
                            count_nxt = 4'd1;
                        end
                    end
                end
                REL_CHK: begin
                    if (!hit) begin
                        if (count + 4'd1 == DB) begin
                            state_nxt = IDLE;
                            count_nxt = '0;
                        end else begin
                            count_nxt = count + 4'd1;
                        end
                    end else begin
                        state_nxt = HELD;
                        count_nxt = '0;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    count_nxt = '0;
                end
            endcase
        end
    end
endmodule

module keypad_entry #(
    parameter int SCAN_DIV = 4,
    parameter int DEBOUNCE = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  row,
    input  logic        btn_enter,
    input  logic        btn_clear,
    output logic [3:0]  col,
    output logic [31:0] data,
    output logic        valid,
    input  logic        ready,
    output logic [3:0]  key_code,
    output logic        key_pulse
);
    localparam int            DW       = $clog2(SCAN_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

    logic [3:0]    row_meta, row_sync;
    logic [1:0]    btn_meta, btn_sync;
    logic [DW-1:0] div_cnt;
    logic [1:0]    col_idx;
    logic          sample, frame_end;
    logic [3:0]    row_low;
    logic [1:0]    col_hits, col_row;
    logic [1:0]    acc_hits;
    logic [3:0]    acc_key;
    logic [2:0]    tot_hits;
    logic          frame_one;
    logic [3:0]    frame_key;
    logic          key_acc, enter_acc, clear_acc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_meta <= '0;
            row_sync <= '0;
            btn_meta <= '0;
            btn_sync <= '0;
        end else begin
            row_meta <= row;
            row_sync <= row_meta;
            btn_meta <= {btn_clear, btn_enter};
            btn_sync <= btn_meta;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
            col_idx <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            col_idx <= col_idx + 2'd1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign col       = ~(4'b0001 << col_idx);
    assign sample    = (div_cnt == DIV_LAST);
    assign frame_end = sample && (col_idx == 2'd3);

    // Hit count saturates at 2: anything beyond a single key classifies the frame as "none".
    always_comb begin
        row_low  = ~row_sync;
        col_hits = 2'd2;
        col_row  = 2'd0;
        case (row_low)
            4'b0000: col_hits = 2'd0;
            4'b0001: begin col_hits = 2'd1; col_row = 2'd0; end
            4'b0010: begin col_hits = 2'd1; col_row = 2'd1; end
            4'b0100: begin col_hits = 2'd1; col_row = 2'd2; end
            4'b1000: begin col_hits = 2'd1; col_row = 2'd3; end
            default: col_hits = 2'd2;
        endcase
        tot_hits  = {1'b0, acc_hits} + {1'b0, col_hits};
        frame_one = (tot_hits == 3'd1);
        frame_key = (col_hits == 2'd1) ? {col_idx, col_row} : acc_key;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_hits <= '0;
            acc_key  <= '0;
        end else if (sample) begin
            if (col_idx == 2'd3) begin
                acc_hits <= '0;
                acc_key  <= '0;
            end else begin
                acc_hits <= (tot_hits >= 3'd2) ? 2'd2 : tot_hits[1:0];
                if (col_hits == 2'd1)
                    acc_key <= {col_idx, col_row};
            end
        end
    end

    keypad_debounce #(.DEBOUNCE(DEBOUNCE)) key_db (
        .clk(clk), .rst(rst), .frame_end(frame_end),
        .hit(frame_one), .code(frame_key), .accept(key_acc)
    );

    keypad_debounce #(.DEBOUNCE(DEBOUNCE)) enter_db (
        .clk(clk), .rst(rst), .frame_end(frame_end),
        .hit(btn_sync[0]), .code(4'd0), .accept(enter_acc)
    );

    keypad_debounce #(.DEBOUNCE(DEBOUNCE)) clear_db (
        .clk(clk), .rst(rst), .frame_end(frame_end),
        .hit(btn_sync[1]), .code(4'd0), .accept(clear_acc)
    );

    // While data is offered, only the consumer handshake may change it; otherwise clear > enter > digit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_pulse <= 1'b0;
            key_code  <= '0;
            data      <= '0;
            valid     <= 1'b0;
        end else begin
            key_pulse <= key_acc;
            if (key_acc)
                key_code <= frame_key;
            if (valid) begin
                if (ready) begin
                    valid <= 1'b0;
                    data  <= '0;
                end
            end else if (clear_acc) begin
                data <= '0;
            end else if (enter_acc) begin
                valid <= 1'b1;
            end else if (key_acc) begin
                data <= {data[27:0], frame_key};
            end
        end
    end
endmodule
